// File: rtl/console_writer_pkg.sv
// Shared console definitions: geometry defaults, control codes, writer states.
package console_writer_pkg;

  localparam int COLS_DEFAULT = 80;
  localparam int ROWS_DEFAULT = 30;
  localparam int ADDR_W       = 12;

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CLR_LINE   = 2'd1,
    CLR_SCREEN = 2'd2
  } state_t;

  // True for the four bytes that move the cursor instead of printing.
  function automatic logic is_control(input logic [7:0] ch);
    return (ch == CH_LF) || (ch == CH_CR) || (ch == CH_BS) || (ch == CH_FF);
  endfunction

endpackage

// File: rtl/console_writer.sv
// Text console writer: turns a byte stream into text-RAM writes, tracks the
// cursor, scrolls by rotating top_row and clears lines / the whole screen.
module console_writer
  import console_writer_pkg::*;
#(
  parameter int          COLS  = COLS_DEFAULT,
  parameter int          ROWS  = ROWS_DEFAULT,
  parameter logic [15:0] BLANK = 16'h0720
) (
  input  logic              clk_pixel,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_char,
  input  logic [7:0]        in_attr,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic [4:0]        top_row,
  output logic [6:0]        cursor_col,
  output logic [4:0]        cursor_row
);

  localparam logic [6:0]        LAST_COL   = 7'(COLS - 1);
  localparam logic [4:0]        LAST_ROW   = 5'(ROWS - 1);
  localparam logic [5:0]        ROWS_W6    = 6'(ROWS);
  localparam logic [ADDR_W-1:0] COLS_A     = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] LINE_LAST  = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] CELLS_LAST = ADDR_W'(ROWS * COLS - 1);

  state_t            state_reg, state_next;
  logic [6:0]        cursor_col_reg, cursor_col_next;
  logic [4:0]        cursor_row_reg, cursor_row_next;
  logic [4:0]        top_row_reg, top_row_next;
  logic [ADDR_W-1:0] clr_cnt_reg, clr_cnt_next;
  logic              wr_en_reg, wr_en_next;
  logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
  logic [15:0]       wr_data_reg, wr_data_next;

  logic              accept;
  logic              advance;
  logic [5:0]        phys_sum;
  logic [4:0]        phys_row;
  logic [ADDR_W-1:0] row_base;
  logic [4:0]        top_inc;

  assign in_ready   = (state_reg == IDLE) && rst_n;
  assign accept     = in_valid && in_ready;
  assign wr_en      = wr_en_reg;
  assign wr_addr    = wr_addr_reg;
  assign wr_data    = wr_data_reg;
  assign top_row    = top_row_reg;
  assign cursor_col = cursor_col_reg;
  assign cursor_row = cursor_row_reg;

  // Physical row under the cursor. During CLR_LINE the cursor sits on the
  // last screen row, which after the scroll is exactly the old top row.
  assign phys_sum = {1'b0, top_row_reg} + {1'b0, cursor_row_reg};
  assign phys_row = (phys_sum >= ROWS_W6) ? 5'(phys_sum - ROWS_W6) : phys_sum[4:0];
  assign row_base = ADDR_W'(phys_row) * COLS_A;
  assign top_inc  = (top_row_reg == LAST_ROW) ? 5'd0 : top_row_reg + 5'd1;

  // Next-state, cursor movement and write generation.
  always_comb begin
    state_next      = state_reg;
    cursor_col_next = cursor_col_reg;
    cursor_row_next = cursor_row_reg;
    top_row_next    = top_row_reg;
    clr_cnt_next    = clr_cnt_reg;
    wr_en_next      = 1'b0;
    wr_addr_next    = wr_addr_reg;
    wr_data_next    = wr_data_reg;
    advance         = 1'b0;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (!is_control(in_char)) begin
            wr_en_next   = 1'b1;
            wr_addr_next = row_base + ADDR_W'(cursor_col_reg);
            wr_data_next = {in_attr, in_char};
            if (cursor_col_reg < LAST_COL) begin
              cursor_col_next = cursor_col_reg + 7'd1;
            end else begin
              cursor_col_next = 7'd0;
              advance         = 1'b1;
            end
          end else if (in_char == CH_LF) begin
            cursor_col_next = 7'd0;
            advance         = 1'b1;
          end else if (in_char == CH_CR) begin
            cursor_col_next = 7'd0;
          end else if (in_char == CH_BS) begin
            if (cursor_col_reg != 7'd0) begin
              cursor_col_next = cursor_col_reg - 7'd1;
            end
          end else begin
            state_next   = CLR_SCREEN;
            clr_cnt_next = '0;
          end

          if (advance) begin
            if (cursor_row_reg < LAST_ROW) begin
              cursor_row_next = cursor_row_reg + 5'd1;
            end else begin
              top_row_next = top_inc;
              state_next   = CLR_LINE;
              clr_cnt_next = '0;
            end
          end
        end
      end

      CLR_LINE: begin
        wr_en_next   = 1'b1;
        wr_addr_next = row_base + clr_cnt_reg;
        wr_data_next = BLANK;
        if (clr_cnt_reg == LINE_LAST) begin
          state_next = IDLE;
        end else begin
          clr_cnt_next = clr_cnt_reg + 1'b1;
        end
      end

      CLR_SCREEN: begin
        wr_en_next   = 1'b1;
        wr_addr_next = clr_cnt_reg;
        wr_data_next = BLANK;
        if (clr_cnt_reg == CELLS_LAST) begin
          state_next      = IDLE;
          top_row_next    = 5'd0;
          cursor_col_next = 7'd0;
          cursor_row_next = 5'd0;
        end else begin
          clr_cnt_next = clr_cnt_reg + 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // State register; reset aborts any clear in progress.
  always_ff @(posedge clk_pixel) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      cursor_col_reg <= '0;
      cursor_row_reg <= '0;
      top_row_reg    <= '0;
      clr_cnt_reg    <= '0;
      wr_en_reg      <= 1'b0;
      wr_addr_reg    <= '0;
      wr_data_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      cursor_col_reg <= cursor_col_next;
      cursor_row_reg <= cursor_row_next;
      top_row_reg    <= top_row_next;
      clr_cnt_reg    <= clr_cnt_next;
      wr_en_reg      <= wr_en_next;
      wr_addr_reg    <= wr_addr_next;
      wr_data_reg    <= wr_data_next;
    end
  end

endmodule
